// File: rtl/rsv_regread_if.sv
`default_nettype none
// ============================================================================
// Module   : rsv_regread_if
// Brief    : Issue, writeback and operand-output signal bundle for rsv_regread.
// Revision : 1.0
// ============================================================================
interface rsv_regread_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [AW-1:0]    rs1_i;
    logic [AW-1:0]    rs2_i;
    logic [AW-1:0]    rd_i;
    logic             rd_wen_i;
    logic             wb_valid_i;
    logic [AW-1:0]    wb_addr_i;
    logic [XLEN-1:0]  wb_data_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  rs1_data_o;
    logic [XLEN-1:0]  rs2_data_o;
    logic [AW-1:0]    rd_o;
    logic             rd_wen_o;
    logic [NREGS-1:0] busy_o;

    modport master (
        output req_valid_i, rs1_i, rs2_i, rd_i, rd_wen_i,
        output wb_valid_i, wb_addr_i, wb_data_i, out_ready_i,
        input  req_ready_o, out_valid_o, rs1_data_o, rs2_data_o,
        input  rd_o, rd_wen_o, busy_o
    );

    modport slave (
        input  req_valid_i, rs1_i, rs2_i, rd_i, rd_wen_i,
        input  wb_valid_i, wb_addr_i, wb_data_i, out_ready_i,
        output req_ready_o, out_valid_o, rs1_data_o, rs2_data_o,
        output rd_o, rd_wen_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/rsv_regread.sv
`default_nettype none
// ============================================================================
// Module   : rsv_regread
// Brief    : RV32I operand-read stage: register file, busy scoreboard,
//            writeback bypass and one-entry operand output register.
// Revision : 1.0
// ============================================================================
module rsv_regread #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    rsv_regread_if.slave   bus
);
    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [AW-1:0]    r_rd;
    logic             r_rd_wen;

    logic             w_wb_rs1;
    logic             w_wb_rs2;
    logic             w_wb_rd;
    logic [XLEN-1:0]  w_rs1_val;
    logic [XLEN-1:0]  w_rs2_val;
    logic             w_haz_rs1;
    logic             w_haz_rs2;
    logic             w_haz_rd;
    logic             w_ready;
    logic             w_accept;
    logic [NREGS-1:0] w_busy_nxt;

    // A same-cycle writeback both supplies the value and retires the hazard.
    always_comb begin
        w_wb_rs1  = bus.wb_valid_i && (bus.wb_addr_i == bus.rs1_i);
        w_wb_rs2  = bus.wb_valid_i && (bus.wb_addr_i == bus.rs2_i);
        w_wb_rd   = bus.wb_valid_i && (bus.wb_addr_i == bus.rd_i);

        w_rs1_val = r_regs[bus.rs1_i];
        if (bus.rs1_i == '0)
            w_rs1_val = '0;
        else if (w_wb_rs1)
            w_rs1_val = bus.wb_data_i;

        w_rs2_val = r_regs[bus.rs2_i];
        if (bus.rs2_i == '0)
            w_rs2_val = '0;
        else if (w_wb_rs2)
            w_rs2_val = bus.wb_data_i;

        w_haz_rs1 = (bus.rs1_i != '0) && r_busy[bus.rs1_i] && !w_wb_rs1;
        w_haz_rs2 = (bus.rs2_i != '0) && r_busy[bus.rs2_i] && !w_wb_rs2;
        w_haz_rd  = bus.rd_wen_i && (bus.rd_i != '0) && r_busy[bus.rd_i] && !w_wb_rd;

        w_ready   = (!r_out_valid || bus.out_ready_i) && !w_haz_rs1 && !w_haz_rs2 && !w_haz_rd;
        w_accept  = bus.req_valid_i && w_ready;
    end

    // Set is applied after clear so a new producer wins over a retiring one.
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.wb_valid_i)
            w_busy_nxt[bus.wb_addr_i] = 1'b0;
        if (w_accept && bus.rd_wen_i && (bus.rd_i != '0))
            w_busy_nxt[bus.rd_i] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (bus.wb_valid_i && (bus.wb_addr_i != '0)) begin
            r_regs[bus.wb_addr_i] <= bus.wb_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_rd        <= '0;
            r_rd_wen    <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_rs1_data  <= w_rs1_val;
            r_rs2_data  <= w_rs2_val;
            r_rd        <= bus.rd_i;
            r_rd_wen    <= bus.rd_wen_i;
        end else if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.out_valid_o = r_out_valid;
    assign bus.rs1_data_o  = r_rs1_data;
    assign bus.rs2_data_o  = r_rs2_data;
    assign bus.rd_o        = r_rd;
    assign bus.rd_wen_o    = r_rd_wen;
    assign bus.busy_o      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_rsv_regread.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsv_regread
// Brief    : Scoreboarded bench for rsv_regread: directed scenarios followed
//            by randomized issue/writeback traffic against a reference model.
// Revision : 1.0
// ============================================================================
module tb_rsv_regread;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rsv_regread_if #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) bus ();

    rsv_regread #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        logic [AW-1:0]   rd;
        logic            wen;
    } exp_t;

    exp_t             q[$];
    int               n_chk  = 0;
    int               n_pass = 0;
    logic [XLEN-1:0]  m_regs [NREGS];
    bit   [NREGS-1:0] m_busy;
    bit               m_ov;

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_busy = '0;
        m_ov   = 1'b0;
        q.delete();
    endtask

    function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] s);
        if (s == 0) return '0;
        if (bus.wb_valid_i && bus.wb_addr_i == s) return bus.wb_data_i;
        return m_regs[s];
    endfunction

    function automatic bit m_pend(input logic [AW-1:0] s);
        return (s != 0) && m_busy[s] && !(bus.wb_valid_i && bus.wb_addr_i == s);
    endfunction

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input bit v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic [AW-1:0] rd, input bit wen, input bit wbv,
                        input logic [AW-1:0] wba, input logic [XLEN-1:0] wbd,
                        input bit ordy, output bit acc);
        bit   exp_rdy;
        exp_t e;
        bus.req_valid_i = v;
        bus.rs1_i       = r1;
        bus.rs2_i       = r2;
        bus.rd_i        = rd;
        bus.rd_wen_i    = wen;
        bus.wb_valid_i  = wbv;
        bus.wb_addr_i   = wba;
        bus.wb_data_i   = wbd;
        bus.out_ready_i = ordy;
        @(negedge clk);
        exp_rdy = (!m_ov || ordy) && !m_pend(r1) && !m_pend(r2) && !(wen && m_pend(rd));
        chk("req_ready", {31'd0, bus.req_ready_o}, {31'd0, exp_rdy});
        chk("out_valid", {31'd0, bus.out_valid_o}, {31'd0, m_ov});
        chk("busy", bus.busy_o, m_busy);
        acc = v && exp_rdy;
        if (acc) begin
            e.r1  = m_read(r1);
            e.r2  = m_read(r2);
            e.rd  = rd;
            e.wen = wen;
            q.push_back(e);
        end
        if (wbv && wba != 0) m_regs[wba] = wbd;
        if (wbv) m_busy[wba] = 1'b0;
        if (acc && wen && rd != 0) m_busy[rd] = 1'b1;
        m_ov = acc ? 1'b1 : (ordy ? 1'b0 : m_ov);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented output must match the oldest outstanding entry.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && bus.out_valid_o) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL out_unexpected: got out_valid=1 expected no pending output at %0t", $time);
                end else begin
                    chk("rs1_data", bus.rs1_data_o, q[0].r1);
                    chk("rs2_data", bus.rs2_data_o, q[0].r2);
                    chk("rd", {27'd0, bus.rd_o}, {27'd0, q[0].rd});
                    chk("rd_wen", {31'd0, bus.rd_wen_o}, {31'd0, q[0].wen});
                    if (bus.out_ready_i) void'(q.pop_front());
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, {31'd0, bus.out_valid_o}, 32'd0);
        chk({tag, "_rs1"}, bus.rs1_data_o, 32'd0);
        chk({tag, "_rs2"}, bus.rs2_data_o, 32'd0);
        chk({tag, "_rd"}, {27'd0, bus.rd_o}, 32'd0);
        chk({tag, "_rd_wen"}, {31'd0, bus.rd_wen_o}, 32'd0);
        chk({tag, "_busy"}, bus.busy_o, 32'd0);
    endtask

    initial begin
        bit              acc;
        bit              pend;
        bit              wbv;
        bit              ordy;
        logic [AW-1:0]   pr1, pr2, prd, wba;
        bit              pwen;

        bus.req_valid_i = 1'b0;
        bus.rs1_i       = '0;
        bus.rs2_i       = '0;
        bus.rd_i        = '0;
        bus.rd_wen_i    = 1'b0;
        bus.wb_valid_i  = 1'b0;
        bus.wb_addr_i   = '0;
        bus.wb_data_i   = '0;
        bus.out_ready_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset_n = 1'b1;

        // Write x5, idle, then read it.
        step(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1, acc);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 1, acc);
        step(1, 5, 0, 0, 0, 0, 0, 32'h0, 1, acc);
        chk("x5_valid", {31'd0, bus.out_valid_o}, 32'd1);
        chk("x5_rs1", bus.rs1_data_o, 32'hDEADBEEF);
        chk("x5_rs2", bus.rs2_data_o, 32'd0);

        // Writeback to x0 is discarded.
        step(0, 0, 0, 0, 0, 1, 0, 32'h1234, 1, acc);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0, 1, acc);
        chk("x0_rs1", bus.rs1_data_o, 32'd0);
        chk("x0_busy0", {31'd0, bus.busy_o[0]}, 32'd0);

        // RAW on x7, resolved by a same-cycle writeback.
        step(1, 1, 2, 7, 1, 0, 0, 32'h0, 1, acc);
        chk("raw_busy7_set", {31'd0, bus.busy_o[7]}, 32'd1);
        step(1, 7, 0, 0, 0, 0, 0, 32'h0, 1, acc);
        chk("raw_stall", {31'd0, bus.req_ready_o}, 32'd0);
        step(1, 7, 0, 0, 0, 0, 0, 32'h0, 1, acc);
        step(1, 7, 0, 0, 0, 1, 7, 32'hA5A5A5A5, 1, acc);
        chk("raw_rs1", bus.rs1_data_o, 32'hA5A5A5A5);
        chk("raw_busy7_clr", {31'd0, bus.busy_o[7]}, 32'd0);

        // WAW on x3 with same-cycle clear: the new set survives.
        step(1, 0, 0, 3, 1, 0, 0, 32'h0, 1, acc);
        step(1, 5, 7, 3, 1, 1, 3, 32'h33333333, 1, acc);
        chk("waw_busy3", {31'd0, bus.busy_o[3]}, 32'd1);

        // Backpressure: outputs frozen for 5 cycles, then back-to-back transfer.
        for (int i = 0; i < 5; i++) step(1, 5, 0, 7, 1, 0, 0, 32'h0, 0, acc);
        chk("hold_rs1", bus.rs1_data_o, 32'hDEADBEEF);
        chk("hold_rs2", bus.rs2_data_o, 32'hA5A5A5A5);
        step(1, 5, 0, 7, 1, 0, 0, 32'h0, 1, acc);
        chk("b2b_valid", {31'd0, bus.out_valid_o}, 32'd1);
        chk("b2b_busy", bus.busy_o, 32'h00000088);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, acc);

        // Asynchronous reset between clock edges.
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async");
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Randomized traffic; stalled requests are held until accepted.
        pend = 1'b0;
        pr1 = '0; pr2 = '0; prd = '0; pwen = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!pend) begin
                pend = ($urandom_range(0, 3) != 0);
                pr1  = AW'($urandom_range(0, NREGS - 1));
                pr2  = AW'($urandom_range(0, NREGS - 1));
                prd  = AW'($urandom_range(0, NREGS - 1));
                pwen = ($urandom_range(0, 2) != 0);
            end
            ordy = ($urandom_range(0, 3) != 0);
            wbv  = ($urandom_range(0, 1) != 0);
            wba  = AW'($urandom_range(0, NREGS - 1));
            if (m_busy != '0 && $urandom_range(0, 3) != 0) begin
                for (int t = 0; t < 64 && !m_busy[wba]; t++)
                    wba = AW'($urandom_range(0, NREGS - 1));
            end
            step(pend, pr1, pr2, prd, pwen, wbv, wba, $urandom, ordy, acc);
            if (acc) pend = 1'b0;
        end

        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 32'h0, 1, acc);
        chk("drain_empty", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
